// File: rtl/savestate_reg_sequencer.sv
// Savestate register-bus initiator: streams every bus register to savestate memory
// behind a magic/count header on save, validates and replays it on load, and issues defaults.
module savestate_reg_sequencer #(
    parameter int unsigned       REG_COUNT = 64,
    parameter int unsigned       MEM_AW    = 16,
    parameter logic [MEM_AW-1:0] MEM_BASE  = '0,
    parameter logic [31:0]       MAGIC     = 32'h4E45_5353
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_save_start,
    input  logic              i_load_start,
    input  logic              i_defaults_req,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [9:0]        o_bus_adr,
    output logic [63:0]       o_bus_din,
    output logic              o_bus_wren,
    output logic              o_bus_rst,
    output logic              o_bus_load,
    input  logic [63:0]       i_bus_dout,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [63:0]       o_mem_wdata,
    input  logic [63:0]       i_mem_rdata,
    input  logic              i_mem_ack
);

    // state     | meaning
    // S_IDLE    | waiting for a start request
    // S_DEF     | bus_rst strobe cycle
    // S_SV_HDR  | writing header word
    // S_SV_ADDR | presenting register index
    // S_SV_CAPT | bus_dout valid, captured at end of cycle
    // S_SV_WR   | writing captured register to memory
    // S_LD_HDR  | reading and validating header word
    // S_LD_RD   | reading one register image (request issued on 2nd cycle)
    // S_LD_WR   | bus_wren strobe for current index
    // S_FIN     | done pulse
    // S_ERR     | error pulse after bad header
    typedef enum logic [3:0] {
        S_IDLE, S_DEF, S_SV_HDR, S_SV_ADDR, S_SV_CAPT, S_SV_WR,
        S_LD_HDR, S_LD_RD, S_LD_WR, S_FIN, S_ERR
    } state_t;

    localparam logic [9:0] LP_CNT  = 10'(REG_COUNT);
    localparam logic [9:0] LP_LAST = 10'(REG_COUNT - 1);

    state_t              r_state;
    logic [9:0]          r_idx;
    logic                r_busy, r_done, r_error, r_bus_wren, r_bus_rst, r_bus_load;
    logic [9:0]          r_bus_adr;
    logic [63:0]         r_bus_din;
    logic                r_mem_req, r_mem_we;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [63:0]         r_mem_wdata;
    logic [MEM_AW-1:0]   w_addr_cur, w_addr_nxt;
    logic                w_hdr_bad;

    assign w_addr_cur = MEM_BASE + MEM_AW'(r_idx) + MEM_AW'(1);
    assign w_addr_nxt = MEM_BASE + MEM_AW'(r_idx) + MEM_AW'(2);
    assign w_hdr_bad  = (i_mem_rdata[63:32] != MAGIC) || (i_mem_rdata[9:0] != LP_CNT);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_bus_wren  <= 1'b0;
            r_bus_rst   <= 1'b0;
            r_bus_load  <= 1'b0;
            r_bus_adr   <= '0;
            r_bus_din   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_bus_wren <= 1'b0;
            r_bus_rst  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (i_save_start) begin
                        r_state     <= S_SV_HDR;
                        r_busy      <= 1'b1;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= MEM_BASE;
                        r_mem_wdata <= {MAGIC, 22'd0, LP_CNT};
                    end else if (i_load_start) begin
                        r_state    <= S_LD_HDR;
                        r_busy     <= 1'b1;
                        r_bus_load <= 1'b1;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= MEM_BASE;
                    end else if (i_defaults_req) begin
                        r_state   <= S_DEF;
                        r_busy    <= 1'b1;
                        r_bus_rst <= 1'b1;
                    end
                end
                S_DEF: begin
                    r_state <= S_FIN;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                S_SV_HDR: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_bus_adr <= r_idx;
                        r_state   <= S_SV_ADDR;
                    end
                end
                S_SV_ADDR: r_state <= S_SV_CAPT;
                S_SV_CAPT: begin
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= w_addr_cur;
                    r_mem_wdata <= i_bus_dout;
                    r_state     <= S_SV_WR;
                end
                S_SV_WR: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (r_idx == LP_LAST) begin
                            r_state <= S_FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx     <= r_idx + 10'd1;
                            r_bus_adr <= r_idx + 10'd1;
                            r_state   <= S_SV_ADDR;
                        end
                    end
                end
                S_LD_HDR: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        if (w_hdr_bad) begin
                            r_state    <= S_ERR;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                            r_bus_load <= 1'b0;
                        end else begin
                            r_mem_addr <= w_addr_cur;
                            r_state    <= S_LD_RD;
                        end
                    end
                end
                // Request is raised one cycle after entry so mem_req always drops after an ack.
                S_LD_RD: begin
                    if (!r_mem_req) begin
                        r_mem_req <= 1'b1;
                    end else if (i_mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_bus_adr  <= r_idx;
                        r_bus_din  <= i_mem_rdata;
                        r_bus_wren <= 1'b1;
                        r_state    <= S_LD_WR;
                    end
                end
                S_LD_WR: begin
                    if (r_idx == LP_LAST) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx      <= r_idx + 10'd1;
                        r_mem_addr <= w_addr_nxt;
                        r_state    <= S_LD_RD;
                    end
                end
                S_FIN: begin
                    r_bus_load <= 1'b0;
                    r_state    <= S_IDLE;
                end
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_bus_adr   = r_bus_adr;
    assign o_bus_din   = r_bus_din;
    assign o_bus_wren  = r_bus_wren;
    assign o_bus_rst   = r_bus_rst;
    assign o_bus_load  = r_bus_load;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: doc/savestate_reg_sequencer.md
Name: savestate_reg_sequencer

Overview:
- Bus initiator for the savestate register bus. Every savestate-capable module (CPU, PPU, APU, mappers, ...) responds on this bus with a 64-bit register at a fixed 10-bit index.
- On save, walks indices 0..REG_COUNT-1, reads each register and streams it to savestate memory behind a one-word header.
- On load, validates the header, then reads memory back and writes each register over the bus.
- Also issues the bus-wide reset-to-defaults strobe. Sits in the top level between the savestate memory arbiter and the module bus.

Parameters:
REG_COUNT, 64, number of bus indices walked (0..REG_COUNT-1), 1..1023
MEM_AW, 16, savestate memory word-address width
MEM_BASE, 0, memory word address of the header word
MAGIC, 32'h4E45_5353, header magic in bits [63:32]

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
save_start  in  1  one-cycle request to save
load_start  in  1  one-cycle request to load
defaults_req  in  1  one-cycle request to reset all registers to defaults
busy  out  1  operation in progress
done  out  1  one-cycle pulse, operation completed OK
error  out  1  one-cycle pulse, load aborted on bad header
bus_adr  out  10  register index
bus_din  out  64  data to registers
bus_wren  out  1  write strobe
bus_rst  out  1  load-defaults strobe
bus_load  out  1  high for the whole load operation
bus_dout  in  64  OR-combined readback from all modules
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  MEM_AW  word address
mem_wdata  out  64  write data
mem_rdata  in  64  read data, valid in the mem_ack cycle
mem_ack  in  1  one-cycle completion

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, index counter is 0.
  - Reset mid-operation abandons it immediately: mem_req drops, and no done or error pulse is issued.
- IDLE behaviour:
  - Start priority: save_start > load_start > defaults_req.
  - Starts are sampled only in IDLE; all starts are ignored while busy.
  - busy goes to 1 the cycle after an accepted start and returns to 0 in the same cycle as done or error.
- Defaults: bus_rst is high exactly one cycle. Next cycle is done=1, then IDLE. busy is high for that one intervening cycle.
- Save sequence:
  - SV_HDR: mem_req=1, mem_we=1, mem_addr=MEM_BASE, mem_wdata={MAGIC, 22'd0, REG_COUNT[9:0]}. Held until mem_ack.
  - SV_ADDR: bus_adr=i.
  - SV_CAPT: bus_adr stays i; bus_dout is captured at the end of this cycle (one-cycle bus read latency).
  - SV_WR: mem_req=1, mem_we=1, mem_addr=MEM_BASE+1+i, mem_wdata=captured value. Held until mem_ack.
  - After ack: if i==REG_COUNT-1, go to FIN; else i++ and go to SV_ADDR.
  - bus_wren is never asserted during a save.
- Load sequence:
  - bus_load=1 from LD_HDR through FIN.
  - LD_HDR: mem_req=1, mem_we=0, mem_addr=MEM_BASE.
    - On ack, if rdata[63:32]!=MAGIC or rdata[9:0]!=REG_COUNT: error=1 for one cycle, then IDLE.
    - In the abort case, no bus_wren is ever issued.
  - LD_RD: read MEM_BASE+1+i; latch mem_rdata on ack.
  - LD_WR: bus_adr=i, bus_din=latched value, bus_wren=1 for exactly one cycle.
  - After LD_WR: last index goes to FIN; else i++ and go to LD_RD.
- FIN: done=1 for one cycle, bus_load drops to 0, then IDLE.
- Address arithmetic: MEM_BASE+1+i, truncated to MEM_AW bits; wrap is the integrator's responsibility.
- Memory handshake:
  - mem_ack while mem_req=0 is ignored.
  - mem_req drops the cycle after ack.
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- Bus outputs:
  - bus_adr/bus_din hold their last value when not strobing.
  - bus_adr is 0 in IDLE after reset.
- Cycle count with zero-wait memory (ack the cycle after req): save = 2 + 4*REG_COUNT cycles, start to done.

Test Plan:
- REG_COUNT=4, registers 0..3 return 64'h11..,22..,33..,44.., instant ack, pulse save_start -> memory writes in order:
  - MEM_BASE: {MAGIC, 22'd0, 10'd4}
  - then 11..,22..,33..,44..
  - then one done pulse, busy low; bus_wren stays 0 throughout.
- Load from that image -> bus_wren pulses at adr 0..3 with matching din; bus_load high from the cycle after start through the done cycle.
- Load with header magic 32'h0 -> one error pulse, zero bus_wren, no done.
- Random mem_ack delays 0..7 cycles plus a spurious ack during IDLE -> identical memory image; outputs stable while req high; spurious ack has no effect.
- save_start and load_start in the same cycle -> save performed; a load_start issued mid-save is ignored (no extra operation after done).
- reset asserted during the write of index 2 of a load -> next cycle all outputs 0 with no done/error pulse; a subsequent defaults_req gives one bus_rst cycle, then done.
